// File: rtl/edge_scan_pkg.sv
// Shared types for the raster edge-scan engine: scan directions, FSM states and default widths.
package edge_scan_pkg;

    localparam int DEF_COORD_W = 10;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_EVAL,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/scan_stepper.sv
// Combinational raster walker: given the current pixel, produces the next pixel in scan order
// and flags whether the current pixel is the last one of the window.
module scan_stepper
    import edge_scan_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int STEP_W  = 4
) (
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [COORD_W-1:0] x_lo,
    input  logic [COORD_W-1:0] x_hi,
    input  logic [COORD_W-1:0] y_lo,
    input  logic [COORD_W-1:0] y_hi,
    input  dir_t               dir,
    input  logic [STEP_W-1:0]  step,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y,
    output logic               is_last
);

    logic               vert;
    logic               dec;
    logic [COORD_W:0]   stp;
    logic [COORD_W:0]   minor_sum;
    logic               minor_past;
    logic [COORD_W-1:0] minor_cur;
    logic [COORD_W-1:0] minor_lo;
    logic [COORD_W-1:0] minor_hi;
    logic [COORD_W-1:0] minor_nxt;
    logic [COORD_W-1:0] major_cur;
    logic [COORD_W-1:0] major_end;
    logic [COORD_W-1:0] major_nxt;

    // The minor step is done one bit wider so the bound test never sees a wrapped coordinate.
    always_comb begin
        vert      = (dir == UP) || (dir == DOWN);
        dec       = (dir == UP) || (dir == LEFT);
        stp       = (COORD_W+1)'(step);
        minor_cur = vert ? cur_y : cur_x;
        minor_lo  = vert ? y_lo : x_lo;
        minor_hi  = vert ? y_hi : x_hi;
        major_cur = vert ? cur_x : cur_y;
        major_end = vert ? (dec ? x_lo : x_hi) : (dec ? y_lo : y_hi);
        if (dec) begin
            minor_sum  = {1'b0, minor_cur} - stp;
            minor_past = minor_sum[COORD_W] || (minor_sum[COORD_W-1:0] < minor_lo);
            minor_nxt  = minor_past ? minor_hi : minor_sum[COORD_W-1:0];
            major_nxt  = minor_past ? (major_cur - 1'b1) : major_cur;
        end else begin
            minor_sum  = {1'b0, minor_cur} + stp;
            minor_past = minor_sum > {1'b0, minor_hi};
            minor_nxt  = minor_past ? minor_lo : minor_sum[COORD_W-1:0];
            major_nxt  = minor_past ? (major_cur + 1'b1) : major_cur;
        end
        nxt_x   = vert ? major_nxt : minor_nxt;
        nxt_y   = vert ? minor_nxt : major_nxt;
        is_last = minor_past && (major_cur == major_end);
    end

endmodule

// File: rtl/raster_edge_scan.sv
// Window-scan engine: walks a pixel window over the cache req/ready handshake and reports the first hit.
// Optional EDGE_SCAN_MIN_RUN_EN: a hit needs RUN_LEN consecutive set pixels along one row/column.
module raster_edge_scan
    import edge_scan_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int STEP_W  = 4,
    parameter int CNT_W   = 20,
    parameter int RUN_LEN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_lo,
    input  logic [COORD_W-1:0] x_hi,
    input  logic [COORD_W-1:0] y_lo,
    input  logic [COORD_W-1:0] y_hi,
    input  logic [1:0]         dir,
    input  logic [STEP_W-1:0]  step,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               aborted,
    output logic               win_err,
    output logic [COORD_W-1:0] found_x,
    output logic [COORD_W-1:0] found_y,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic               req,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic               ready,
    input  logic               pixel
);

    scan_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] found_x_q, found_x_d, found_y_q, found_y_d;
    dir_t               dir_q, dir_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               pixel_q, pixel_d, found_q, found_d, aborted_q, aborted_d, win_err_q, win_err_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [COORD_W-1:0] nxt_x, nxt_y, hit_x, hit_y;
    logic               is_last, hit_now, start_ok;

    scan_stepper #(.COORD_W(COORD_W), .STEP_W(STEP_W)) u_stepper (
        .cur_x(cur_x_q), .cur_y(cur_y_q),
        .x_lo(x_lo_q), .x_hi(x_hi_q), .y_lo(y_lo_q), .y_hi(y_hi_q),
        .dir(dir_q), .step(step_q),
        .nxt_x(nxt_x), .nxt_y(nxt_y), .is_last(is_last)
    );

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef EDGE_SCAN_MIN_RUN_EN
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [COORD_W-1:0] run_x_q, run_x_d, run_y_q, run_y_d;
    logic               minor_wrap;

    // A run is remembered by its first pixel; leaving the row/column breaks it.
    always_comb begin
        run_cnt_d  = run_cnt_q;
        run_x_d    = run_x_q;
        run_y_d    = run_y_q;
        minor_wrap = ((dir_q == UP) || (dir_q == DOWN)) ? (nxt_x != cur_x_q) : (nxt_y != cur_y_q);
        hit_now    = pixel_q && (run_cnt_q == RUN_W'(RUN_LEN - 1));
        hit_x      = (run_cnt_q == '0) ? cur_x_q : run_x_q;
        hit_y      = (run_cnt_q == '0) ? cur_y_q : run_y_q;
        if (start_ok) begin
            run_cnt_d = '0;
        end else if (state_q == ST_EVAL) begin
            if (pixel_q) begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == '0) begin
                    run_x_d = cur_x_q;
                    run_y_d = cur_y_q;
                end
            end else begin
                run_cnt_d = '0;
            end
            if (minor_wrap) begin
                run_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            run_x_q   <= '0;
            run_y_q   <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
            run_x_q   <= run_x_d;
            run_y_q   <= run_y_d;
        end
    end
`else
    assign hit_now = pixel_q;
    assign hit_x   = cur_x_q;
    assign hit_y   = cur_y_q;
`endif

    // Abort outranks both a pending cache response and a hit in the same cycle.
    always_comb begin
        state_d   = state_q;
        x_lo_d    = x_lo_q;
        x_hi_d    = x_hi_q;
        y_lo_d    = y_lo_q;
        y_hi_d    = y_hi_q;
        dir_d     = dir_q;
        step_d    = step_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        pixel_d   = pixel_q;
        found_d   = found_q;
        aborted_d = aborted_q;
        win_err_d = win_err_q;
        found_x_d = found_x_q;
        found_y_d = found_y_q;
        pix_cnt_d = pix_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    x_lo_d    = x_lo;
                    x_hi_d    = x_hi;
                    y_lo_d    = y_lo;
                    y_hi_d    = y_hi;
                    dir_d     = dir_t'(dir);
                    step_d    = (step == '0) ? STEP_W'(1) : step;
                    cur_x_d   = ((dir_t'(dir) == UP) || (dir_t'(dir) == LEFT)) ? x_hi : x_lo;
                    cur_y_d   = ((dir_t'(dir) == UP) || (dir_t'(dir) == LEFT)) ? y_hi : y_lo;
                    found_d   = 1'b0;
                    aborted_d = 1'b0;
                    win_err_d = 1'b0;
                    found_x_d = '0;
                    found_y_d = '0;
                    pix_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if ((x_lo_q > x_hi_q) || (y_lo_q > y_hi_q)) begin
                    state_d   = ST_DONE;
                    win_err_d = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (ready) begin
                    state_d = ST_EVAL;
                    pixel_d = pixel;
                end
            end
            ST_EVAL: begin
                if (pix_cnt_q != '1) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (hit_now) begin
                    state_d   = ST_DONE;
                    found_d   = 1'b1;
                    found_x_d = hit_x;
                    found_y_d = hit_y;
                end else if (is_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                    cur_x_d = nxt_x;
                    cur_y_d = nxt_y;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_lo_q    <= '0;
            x_hi_q    <= '0;
            y_lo_q    <= '0;
            y_hi_q    <= '0;
            dir_q     <= UP;
            step_q    <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            pixel_q   <= 1'b0;
            found_q   <= 1'b0;
            aborted_q <= 1'b0;
            win_err_q <= 1'b0;
            found_x_q <= '0;
            found_y_q <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            x_lo_q    <= x_lo_d;
            x_hi_q    <= x_hi_d;
            y_lo_q    <= y_lo_d;
            y_hi_q    <= y_hi_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            pixel_q   <= pixel_d;
            found_q   <= found_d;
            aborted_q <= aborted_d;
            win_err_q <= win_err_d;
            found_x_q <= found_x_d;
            found_y_q <= found_y_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_REQ) || (state_q == ST_EVAL);
    assign done    = (state_q == ST_DONE);
    assign req     = (state_q == ST_REQ);
    assign rd_x    = cur_x_q;
    assign rd_y    = cur_y_q;
    assign found   = found_q;
    assign aborted = aborted_q;
    assign win_err = win_err_q;
    assign found_x = found_x_q;
    assign found_y = found_y_q;
    assign pix_cnt = pix_cnt_q;

endmodule

// File: tb/tb_raster_edge_scan.sv
// Scoreboard bench for raster_edge_scan: a small pixel-cache model answers requests, and a
// monitor checks every finished scan and every requested address against queued expectations.
module tb_raster_edge_scan;

    localparam int CW = 10;
    localparam int SW = 4;
    localparam int NW = 4;

    typedef struct {
        logic found;
        logic aborted;
        logic win_err;
        int   fx;
        int   fy;
        int   pix;
        int   nreq;
        int   req_base;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] x_lo = '0, x_hi = '0, y_lo = '0, y_hi = '0;
    logic [1:0]    dir_in = '0;
    logic [SW-1:0] step = '0;
    logic          busy, done, found, aborted, win_err, req;
    logic [CW-1:0] found_x, found_y, rd_x, rd_y;
    logic [NW-1:0] pix_cnt;
    logic          ready = 1'b0;
    logic          pixel = 1'b0;

    exp_t        exp_q[$];
    logic [19:0] addr_q[$];
    logic [19:0] hit_q[$];
    int          errors = 0;
    int          checks = 0;
    int          req_total = 0;
    logic        cache_en = 1'b1;
    logic        req_prev = 1'b0;
    logic        done_prev = 1'b0;

    raster_edge_scan #(.COORD_W(CW), .STEP_W(SW), .CNT_W(NW), .RUN_LEN(3)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
        .dir(dir_in), .step(step),
        .busy(busy), .done(done), .found(found), .aborted(aborted), .win_err(win_err),
        .found_x(found_x), .found_y(found_y), .pix_cnt(pix_cnt),
        .req(req), .rd_x(rd_x), .rd_y(rd_y), .ready(ready), .pixel(pixel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic logic isHit(input logic [CW-1:0] x, input logic [CW-1:0] y);
        foreach (hit_q[i]) begin
            if (hit_q[i] == {x, y}) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Cache model and scoreboard monitor, both sampling away from the active edge.
    always @(negedge clk) begin
        if (ready) begin
            ready = 1'b0;
        end else if (req && cache_en) begin
            ready = 1'b1;
            pixel = isHit(rd_x, rd_y);
        end
        if (req && !req_prev) begin
            req_total++;
            if (addr_q.size() > 0) checkOutput("rd_addr", {12'd0, rd_x, rd_y}, {12'd0, addr_q.pop_front()});
        end
        req_prev = req;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no scan completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("found", found, e.found);
                checkOutput("aborted", aborted, e.aborted);
                checkOutput("win_err", win_err, e.win_err);
                checkOutput("found_x", found_x, e.fx);
                checkOutput("found_y", found_y, e.fy);
                checkOutput("pix_cnt", pix_cnt, e.pix);
                checkOutput("nreq", req_total - e.req_base, e.nreq);
            end
        end
        done_prev = done;
    end

    task automatic applyStimulus(input logic [1:0] d, input int xl, input int yl, input int xh, input int yh,
                                 input int st, input bit expect_done, input logic ef, input logic ea,
                                 input logic ew, input int efx, input int efy, input int epix, input int enreq);
        exp_t e;
        dir_in = d;
        x_lo   = CW'(xl);
        y_lo   = CW'(yl);
        x_hi   = CW'(xh);
        y_hi   = CW'(yh);
        step   = SW'(st);
        e = '{found: ef, aborted: ea, win_err: ew, fx: efx, fy: efy, pix: epix, nreq: enreq,
              req_base: req_total};
        if (expect_done) exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, expected done=1", limit);
            exp_q.delete();
            addr_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic waitReq(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req && n < limit);
        if (!req) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout: got req=0 after %0d cycles, expected req=1", limit);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"}, {busy, done, found, aborted, win_err, req}, 0);
        checkOutput({tag, "_coord"}, {found_x, found_y, rd_x, rd_y}, 0);
        checkOutput({tag, "_cnt"}, pix_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        // RIGHT scan, single hit at (2,1) is the 7th pixel.
        hit_q = '{{10'd2, 10'd1}};
        addr_q = '{{10'd0, 10'd0}, {10'd1, 10'd0}, {10'd2, 10'd0}, {10'd3, 10'd0},
                   {10'd0, 10'd1}, {10'd1, 10'd1}, {10'd2, 10'd1}};
        applyStimulus(2'd3, 0, 0, 3, 2, 1, 1, 1, 0, 0, 2, 1, 7, 7);
        waitDone(100);

        // UP over 20 empty pixels: ends at (0,0), pixel counter saturates at 15.
        hit_q.delete();
        applyStimulus(2'd0, 0, 0, 3, 4, 1, 1, 0, 0, 0, 0, 0, 15, 20);
        waitDone(200);

        // Stride boundaries: no wrap below 0, no wrap above 1023, step 0 behaves as 1.
        addr_q = '{{10'd0, 10'd2}, {10'd0, 10'd0}};
        applyStimulus(2'd0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 0, 0, 2, 2);
        waitDone(50);
        addr_q = '{{10'd1020, 10'd7}, {10'd1023, 10'd7}};
        applyStimulus(2'd3, 1020, 7, 1023, 7, 3, 1, 0, 0, 0, 0, 0, 2, 2);
        waitDone(50);
        addr_q = '{{10'd2, 10'd2}, {10'd2, 10'd3}, {10'd2, 10'd4}};
        applyStimulus(2'd1, 2, 2, 2, 4, 0, 1, 0, 0, 0, 0, 0, 3, 3);
        waitDone(50);

        // DOWN with stride 4, and a start pulse during the scan that must be ignored.
        addr_q = '{{10'd5, 10'd5}, {10'd5, 10'd9}, {10'd6, 10'd5}, {10'd6, 10'd9}};
        applyStimulus(2'd1, 5, 5, 6, 12, 4, 1, 0, 0, 0, 0, 0, 4, 4);
        repeat (4) @(negedge clk);
        dir_in = 2'd0;
        x_lo   = 10'd0;
        step   = 4'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitDone(100);

        // Inverted window: done two cycles after start, no request.
        applyStimulus(2'd3, 8, 0, 3, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("werr_cycle1_done", done, 0);
        @(negedge clk);
        checkOutput("werr_cycle2_done", done, 1);
        waitDone(10);

        // Single-pixel window with a hit.
        hit_q = '{{10'd7, 10'd7}};
        addr_q = '{{10'd7, 10'd7}};
        applyStimulus(2'd3, 7, 7, 7, 7, 1, 1, 1, 0, 0, 7, 7, 1, 1);
        waitDone(50);

        // LEFT row with a broken run then a full run.
        hit_q = '{{10'd9, 10'd1}, {10'd8, 10'd1}, {10'd5, 10'd1}, {10'd4, 10'd1}, {10'd3, 10'd1}};
`ifdef EDGE_SCAN_MIN_RUN_EN
        applyStimulus(2'd2, 0, 0, 9, 1, 1, 1, 1, 0, 0, 5, 1, 7, 7);
`else
        applyStimulus(2'd2, 0, 0, 9, 1, 1, 1, 1, 0, 0, 9, 1, 1, 1);
`endif
        waitDone(100);

        // Hits straddling the row change.
        hit_q = '{{10'd1, 10'd1}, {10'd0, 10'd1}, {10'd9, 10'd0}};
`ifdef EDGE_SCAN_MIN_RUN_EN
        applyStimulus(2'd2, 0, 0, 9, 1, 1, 1, 0, 0, 0, 0, 0, 15, 20);
`else
        applyStimulus(2'd2, 0, 0, 9, 1, 1, 1, 1, 0, 0, 1, 1, 9, 9);
`endif
        waitDone(200);

        // Abort while the request is stalled on the cache.
        hit_q = '{{10'd0, 10'd0}};
        cache_en = 1'b0;
        applyStimulus(2'd3, 0, 0, 3, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        waitReq(20);
        repeat (2) @(negedge clk);
        checkOutput("stall_req_held", req, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cache_en = 1'b1;
        waitDone(20);

        // Abort in the same cycle as a ready carrying a hit.
        applyStimulus(2'd3, 0, 0, 3, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        waitReq(20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitDone(20);

        // Reset in the middle of a scan, then a clean scan afterwards.
        hit_q.delete();
        applyStimulus(2'd0, 0, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", {busy, done, req}, 0);
        hit_q = '{{10'd7, 10'd7}};
        applyStimulus(2'd1, 7, 7, 7, 7, 1, 1, 1, 0, 0, 7, 7, 1, 1);
        waitDone(50);

        checkOutput("sb_empty", exp_q.size(), 0);
        checkOutput("addr_empty", addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
